// File: rtl/imm_narrow_encoder.sv
// Narrows 16-bit constants into a sign-extendable short byte or a high/low byte pair.
// Optional feature: define IMM_COMPACT_EN to enable short-byte fit detection.
module imm_narrow_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [1:0]  out_kind,
    output logic        out_last,
    output logic [7:0]  short_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShort = 2'd1;
    localparam logic [1:0] StHi    = 2'd2;
    localparam logic [1:0] StLo    = 2'd3;

    localparam logic [1:0] KindShort = 2'b00;
    localparam logic [1:0] KindHi    = 2'b01;
    localparam logic [1:0] KindLo    = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic [1:0]  out_kind_q, out_kind_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  short_count_q, short_count_d;
    logic        fits;

`ifdef IMM_COMPACT_EN
    // Sign-extending the low byte reproduces the value iff bits [15:7] agree.
    assign fits = (in_value[15:8] == {8{in_value[7]}});
`else
    assign fits = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        out_valid_d   = out_valid_q;
        out_byte_d    = out_byte_q;
        out_kind_d    = out_kind_q;
        out_last_d    = out_last_q;
        short_count_d = short_count_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    hold_d      = in_value;
                    out_valid_d = 1'b1;
                    if (fits) begin
                        state_d    = StShort;
                        out_byte_d = in_value[7:0];
                        out_kind_d = KindShort;
                        out_last_d = 1'b1;
                    end else begin
                        state_d    = StHi;
                        out_byte_d = in_value[15:8];
                        out_kind_d = KindHi;
                        out_last_d = 1'b0;
                    end
                end
            end
            StShort: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    if (short_count_q != 8'hFF) begin
                        short_count_d = short_count_q + 8'd1;
                    end
                end
            end
            StHi: begin
                if (out_ready) begin
                    state_d    = StLo;
                    out_byte_d = hold_q[7:0];
                    out_kind_d = KindLo;
                    out_last_d = 1'b1;
                end
            end
            StLo: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            hold_q        <= 16'h0000;
            out_valid_q   <= 1'b0;
            out_byte_q    <= 8'h00;
            out_kind_q    <= 2'b00;
            out_last_q    <= 1'b0;
            short_count_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            out_valid_q   <= out_valid_d;
            out_byte_q    <= out_byte_d;
            out_kind_q    <= out_kind_d;
            out_last_q    <= out_last_d;
            short_count_q <= short_count_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign out_byte    = out_byte_q;
    assign out_kind    = out_kind_q;
    assign out_last    = out_last_q;
    assign short_count = short_count_q;

endmodule
